// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button conditioner.
// The long-press feature is compiled in only when BTN_LONG_PRESS_EN is defined.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    // 10 ms debounce and 1 s long press at the 100 MHz board clock
    localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
    localparam int LONG_CYCLES_DEF     = 100_000_000;

    localparam int PRESS_CNT_W = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser bringing the raw button into the clk domain.
// Synchronous active-low reset clears both stages to 0.
module btn_sync
    import btn_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic [1:0] stage_reg;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            stage_reg <= 2'b00;
        end else begin
            stage_reg <= {stage_reg[0], d};
        end
    end

    assign q = stage_reg[1];

endmodule

// File: rtl/btn_conditioner.sv
// Push-button conditioner: synchronise, debounce, press/release pulses and a press count.
// Define BTN_LONG_PRESS_EN to add the one-shot long-press pulse on btn_long.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   btn,
    output logic                   btn_level,
    output logic                   btn_press,
    output logic                   btn_release,
    output logic                   btn_long,
    output logic [PRESS_CNT_W-1:0] press_cnt
);

`ifdef BTN_LONG_PRESS_EN
    localparam int CNT_RANGE = max_int(DEBOUNCE_CYCLES, LONG_CYCLES);
`else
    localparam int CNT_RANGE = DEBOUNCE_CYCLES;
`endif
    localparam int CNT_W = (CNT_RANGE > 1) ? $clog2(CNT_RANGE) : 1;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    generate
        if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 1) begin : g_param_check
            $error("btn_conditioner: DEBOUNCE_CYCLES must be >= 2 and LONG_CYCLES >= 1");
        end
    endgenerate

    logic s2;

    btn_sync u_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (btn),
        .q    (s2)
    );

    btn_state_t             state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic                   level_reg, level_next;
    logic                   press_reg, press_next;
    logic                   release_reg, release_next;
    logic [PRESS_CNT_W-1:0] press_cnt_reg, press_cnt_next;

`ifdef BTN_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

    // armed only during the first uninterrupted stretch of a press
    logic long_armed_reg, long_armed_next;
    logic long_reg, long_next;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            long_armed_reg <= 1'b0;
            long_reg       <= 1'b0;
        end else begin
            long_armed_reg <= long_armed_next;
            long_reg       <= long_next;
        end
    end

    assign btn_long = long_reg;
`else
    assign btn_long = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            level_reg     <= 1'b0;
            press_reg     <= 1'b0;
            release_reg   <= 1'b0;
            press_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            level_reg     <= level_next;
            press_reg     <= press_next;
            release_reg   <= release_next;
            press_cnt_reg <= press_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        level_next     = level_reg;
        press_next     = 1'b0;
        release_next   = 1'b0;
        press_cnt_next = press_cnt_reg;
`ifdef BTN_LONG_PRESS_EN
        long_armed_next = long_armed_reg;
        long_next       = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (s2) begin
                    state_next = PRESS_WAIT;
                    cnt_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s2) begin
                    state_next = IDLE;
                end else if (cnt_reg == DB_LAST) begin
                    state_next     = PRESSED;
                    level_next     = 1'b1;
                    press_next     = 1'b1;
                    press_cnt_next = press_cnt_reg + PRESS_CNT_W'(1);
`ifdef BTN_LONG_PRESS_EN
                    cnt_next        = '0;
                    long_armed_next = 1'b1;
`endif
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!s2) begin
                    state_next = RELEASE_WAIT;
                    cnt_next   = '0;
`ifdef BTN_LONG_PRESS_EN
                    long_armed_next = 1'b0;
                end else if (long_armed_reg) begin
                    // fire once, then hold cnt where it is
                    if (cnt_reg == LONG_LAST) begin
                        long_next       = 1'b1;
                        long_armed_next = 1'b0;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
`endif
                end
            end
            RELEASE_WAIT: begin
                if (s2) begin
                    state_next = PRESSED;
                end else if (cnt_reg == DB_LAST) begin
                    state_next   = IDLE;
                    level_next   = 1'b0;
                    release_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign btn_level   = level_reg;
    assign btn_press   = press_reg;
    assign btn_release = release_reg;
    assign press_cnt   = press_cnt_reg;

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Input-side conditioner for a push button on the 100 MHz board clock (10 ns period). It synchronises the raw `btn`, debounces it and emits a clean level, one-cycle press/release pulses and an 8-bit wrapping press count. The outputs feed the LED flasher and the `led[7:0]` display. It is the producer end of the button interface that the flasher consumes.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000 (10 ms); stable cycles required to accept a level change; must be ≥ 2.
- `LONG_CYCLES`, default 100_000_000 (1 s); held cycles for a long press; only used with the macro.
- `clk`  in  1  board clock, rising edge.
- `rstn`  in  1  reset, synchronous, active-low.
- `btn`  in  1  raw asynchronous button, high = pressed.
- `btn_level`  out  1  debounced level.
- `btn_press`  out  1  one-cycle pulse on an accepted press.
- `btn_release`  out  1  one-cycle pulse on an accepted release.
- `btn_long`  out  1  one-cycle pulse on a long press; tied 0 without the macro.
- `press_cnt`  out  8  accepted presses modulo 256.

## Operation
- Synchroniser: `btn` → s1 → s2, two flops. The FSM reads only s2.
- Debounce counter `cnt` has width $clog2 of the larger of DEBOUNCE_CYCLES and LONG_CYCLES.
- IDLE:
  - s2=1 → PRESS_WAIT, cnt←0.
- PRESS_WAIT:
  - s2=0 → IDLE; bounce rejected, no outputs change.
  - Otherwise, cnt==DEBOUNCE_CYCLES-1 → PRESSED. On that same edge: btn_level←1, btn_press←1, press_cnt←press_cnt+1.
  - Otherwise cnt←cnt+1.
- PRESSED:
  - s2=0 → RELEASE_WAIT, cnt←0.
  - Long counting is described under Configuration.
- RELEASE_WAIT:
  - s2=1 → PRESSED; glitch rejected, no new press pulse.
  - Otherwise, cnt==DEBOUNCE_CYCLES-1 → IDLE. On that edge: btn_level←0, btn_release←1.
  - Otherwise cnt←cnt+1.
- Pulses are registered and high for exactly one cycle. btn_press and btn_release are never high together.
- press_cnt wraps 255 → 0 with no flag.

## Timing
- Reset: when `rstn`=0 at an edge, s1, s2, cnt, press_cnt and all outputs go to 0, and the state goes to IDLE.
  - Reset mid-debounce or mid-press emits no pulse.
  - If `btn` is held through reset release, it is treated as a new press.
- Press latency: let edge 1 be the first edge sampling `btn`=1. btn_press and btn_level rise at edge DEBOUNCE_CYCLES+3, provided `btn` stays high throughout.
- Release latency is the same, measured from the first edge sampling `btn`=0.
- A low sample anywhere in PRESS_WAIT aborts it. The next high sample restarts from cnt=0, so the full DEBOUNCE_CYCLES must pass again.
- Outputs change only on rising `clk`. There are no combinational paths from `btn`.

## Configuration
- Macro `BTN_LONG_PRESS_EN`.
- Defined:
  - On entering PRESSED, cnt←0; cnt then increments each cycle while in PRESSED.
  - When cnt==LONG_CYCLES-1, btn_long pulses once and cnt saturates. At most one btn_long per press.
  - A glitch return from RELEASE_WAIT to PRESSED does not restart long counting and does not re-fire btn_long.
- Undefined:
  - btn_long is constant 0 and there is no long-count logic.
  - cnt is sized by DEBOUNCE_CYCLES only.

## Structure
- Package `btn_pkg` holds:
  - the state enum (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT);
  - default constants for DEBOUNCE_CYCLES and LONG_CYCLES;
  - the press_cnt width (8).
- One sub-module, `btn_sync`: a 2-flop synchroniser with synchronous active-low reset to 0.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, LONG_CYCLES=10 and a 10 ns clock.
- Clean press: `btn`=1 held → btn_press high exactly at edge 7 for one cycle; btn_level=1; press_cnt=1.
- Bounce rejection: `btn` toggles 1,0,1,0 on successive cycles, then stays 0 → no pulse; btn_level=0; press_cnt=0.
- Release glitch: 2-cycle low during a hold → no btn_release and no second btn_press. A real release of 8 cycles → btn_release at edge 7 of the release.
- Wrap: 256 clean presses → press_cnt=0; btn_press count equals 256.
- Reset mid-press: `rstn`=0 for one edge while in PRESS_WAIT → all outputs 0 next cycle, no pulse. `btn` still high → btn_press at edge 7 after reset release.
- Long press, with BTN_LONG_PRESS_EN: hold 30 cycles → exactly one btn_long, at the 10th cycle in PRESSED. Without the macro: btn_long stays 0.
